data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 17 +
 rtl/dmr_storage.sv | 40 ++++
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage.
package data_mem_responder_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned DEF_ADDR_W  = 6;
    localparam int unsigned DEF_LATENCY = 2;
    localparam int unsigned TXN_W       = 16;
    // Wide enough for the largest preload value, LATENCY-2 = 13.
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmr_storage.sv
// Word-addressed storage: one synchronous write port and one registered read port, no reset.
module dmr_storage
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_q [0:DEPTH-1];
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] rd_data_d;

    // Read register only updates when a read is requested, so it holds while a response waits.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Array write and read-data register; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder with fixed accept-to-response latency.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [31:0]              req_addr,
    input  logic signed [WORD_W-1:0] req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WORD_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [TXN_W-1:0]         txn_count
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic               err_q, err_d;
    logic               load_ok_q, load_ok_d;
    logic [TXN_W-1:0]   txn_q, txn_d;

    logic               in_idle;
    logic               enter_resp;
    logic               cur_we;
    logic [31:0]        cur_addr;
    logic [WORD_W-1:0]  cur_wdata;
    logic               cur_oor;
    logic               mem_we;
    logic               mem_re;
    logic [WORD_W-1:0]  mem_rdata;

    // With LATENCY=1 RESP is entered on the accept edge itself, before the capture
    // registers hold the request, so the live inputs are used in IDLE.
    always_comb begin
        in_idle    = (state_q == IDLE);
        cur_we     = in_idle ? req_we    : we_q;
        cur_addr   = in_idle ? req_addr  : addr_q;
        cur_wdata  = in_idle ? req_wdata : wdata_q;
        cur_oor    = (cur_addr[31:ADDR_W] != '0);
        enter_resp = (in_idle && req_valid && (LATENCY == 1)) ||
                     ((state_q == WAIT) && (cnt_q == '0));
        mem_we     = enter_resp && cur_we && !cur_oor;
        mem_re     = enter_resp && !cur_we && !cur_oor;
    end

    // Next-state, latency countdown, request capture and handshake counting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        load_ok_d = load_ok_q;
        txn_d     = txn_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d   = IDLE;
                    err_d     = 1'b0;
                    load_ok_d = 1'b0;
                    if (txn_q != '1) begin
                        txn_d = txn_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            err_d     = cur_oor;
            load_ok_d = !cur_we && !cur_oor;
        end
    end

    // Control and capture registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
            txn_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            load_ok_q <= load_ok_d;
            txn_q     <= txn_d;
        end
    end

    dmr_storage #(
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk     (CLK),
        .wr_en   (mem_we),
        .wr_addr (cur_addr[ADDR_W-1:0]),
        .wr_data (cur_wdata),
        .rd_en   (mem_re),
        .rd_addr (cur_addr[ADDR_W-1:0]),
        .rd_data (mem_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;
    // Storage read register is not reset, so load data is gated by a reset flop.
    assign rsp_rdata = load_ok_q ? mem_rdata : '0;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 instance checked by vector table, hand sequences
// and random traffic against an array model, plus a LATENCY=1 instance for back-to-back timing.
module tb_data_mem_responder;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0;
    logic [31:0] a_req_addr = '0;
    logic signed [31:0] a_req_wdata = '0;
    logic        a_rsp_valid, a_rsp_ready = 1'b0, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic [15:0] a_txn_count;

    logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
    logic [31:0] b_req_addr = '0;
    logic signed [31:0] b_req_wdata = '0;
    logic        b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic [15:0] b_txn_count;

    data_mem_responder #(.ADDR_W(6), .LATENCY(2)) dut_a (
        .CLK(CLK), .RST(RST),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .txn_count(a_txn_count)
    );

    data_mem_responder #(.ADDR_W(6), .LATENCY(1)) dut_b (
        .CLK(CLK), .RST(RST),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .txn_count(b_txn_count)
    );

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    // Reference model: word array for instance A plus expected handshake count.
    logic [31:0] mem_model [0:63];
    logic [15:0] exp_txn = '0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_req_ready"}, 32'(a_req_ready), 32'd1);
        chk({tag, "_a_rsp_valid"}, 32'(a_rsp_valid), 32'd0);
        chk({tag, "_a_rsp_err"},   32'(a_rsp_err),   32'd0);
        chk({tag, "_a_rsp_rdata"}, a_rsp_rdata,      32'd0);
        chk({tag, "_a_txn"},       32'(a_txn_count), 32'd0);
        chk({tag, "_b_req_ready"}, 32'(b_req_ready), 32'd1);
        chk({tag, "_b_rsp_valid"}, 32'(b_rsp_valid), 32'd0);
        chk({tag, "_b_txn"},       32'(b_txn_count), 32'd0);
    endtask

    // One full transaction on instance A with `hold` stalled cycles in RESP.
    task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int unsigned hold, output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int unsigned lat;
        exp_er = (addr[31:6] != '0);
        exp_rd = (we || exp_er) ? 32'd0 : mem_model[addr[5:0]];
        @(negedge CLK);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_rsp_ready = 1'b0;
        chk("req_ready", 32'(a_req_ready), 32'd1);
        @(posedge CLK);
        #1;
        if (we && !exp_er) mem_model[addr[5:0]] = wdata;
        // Request stays asserted with scrambled fields; it must be ignored.
        a_req_we    = ~we;
        a_req_addr  = $urandom;
        a_req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!a_rsp_valid && lat < 20);
        chk("latency", 32'(lat), 32'd2);
        rd = a_rsp_rdata;
        er = a_rsp_err;
        chk("rsp_rdata", a_rsp_rdata, exp_rd);
        chk("rsp_err", 32'(a_rsp_err), 32'(exp_er));
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge CLK);
            chk("hold_valid", 32'(a_rsp_valid), 32'd1);
            chk("hold_rdata", a_rsp_rdata, exp_rd);
            chk("hold_err", 32'(a_rsp_err), 32'(exp_er));
            chk("hold_req_ready", 32'(a_req_ready), 32'd0);
            chk("hold_txn", 32'(a_txn_count), 32'(exp_txn));
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        a_rsp_ready = 1'b0;
        if (exp_txn != 16'hFFFF) exp_txn = exp_txn + 16'd1;
        chk("txn_count", 32'(a_txn_count), 32'(exp_txn));
        chk("back_idle_ready", 32'(a_req_ready), 32'd1);
        chk("back_idle_valid", 32'(a_rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        we;
        logic [31:0] addr;
        logic [31:0] prior3;

        vecs[0] = '{1'b1, 32'd5,          32'hDEADBEEF, 32'd0,        1'b0};
        vecs[1] = '{1'b0, 32'd5,          32'd0,        32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h40,         32'd0,        32'd0,        1'b1};
        vecs[3] = '{1'b0, 32'd0,          32'd0,        32'hA5000000, 1'b0};
        vecs[4] = '{1'b1, 32'h40,         32'h55555555, 32'd0,        1'b1};
        vecs[5] = '{1'b0, 32'd0,          32'd0,        32'hA5000000, 1'b0};
        vecs[6] = '{1'b1, 32'd63,         32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[7] = '{1'b0, 32'd63,         32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[8] = '{1'b0, 32'h80000001,   32'd0,        32'd0,        1'b1};
        vecs[9] = '{1'b0, 32'd1,          32'd0,        32'hA5000001, 1'b0};

        // Reset values.
        @(negedge CLK);
        chk_reset_outputs("por");
        @(negedge CLK);
        RST = 1'b1;

        // Known contents everywhere: word i holds 0xA5000000 | i.
        for (int unsigned i = 0; i < 64; i++) begin
            txn_a(1'b1, 32'(i), 32'hA5000000 | 32'(i), 0, rd, er);
        end

        // Vector table.
        for (int unsigned i = 0; i < 10; i++) begin
            txn_a(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Stalled response: five cycles with rsp_ready low.
        txn_a(1'b0, 32'd5, 32'd0, 5, rd, er);
        chk("stall_rdata", rd, 32'hDEADBEEF);
        txn_a(1'b0, 32'h41, 32'd0, 5, rd, er);
        chk("stall_err", 32'(er), 32'd1);

        // Reset while a store to addr 3 sits in WAIT: the store must be lost.
        prior3 = mem_model[3];
        @(negedge CLK);
        a_req_valid = 1'b1;
        a_req_we    = 1'b1;
        a_req_addr  = 32'd3;
        a_req_wdata = 32'h00001234;
        @(posedge CLK);
        #1;
        a_req_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(posedge CLK);
        #1;
        chk_reset_outputs("mid_rst_edge");
        @(negedge CLK);
        RST = 1'b1;
        exp_txn = '0;
        txn_a(1'b0, 32'd3, 32'd0, 0, rd, er);
        chk("rst_store_dropped", rd, prior3);

        // Random traffic against the model.
        for (int unsigned i = 0; i < 150; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h40) : 32'($urandom_range(0, 63));
            txn_a(we, addr, $urandom, $urandom_range(0, 3), rd, er);
        end

        // Saturation from a preloaded count of 0xFFFE.
        @(negedge CLK);
        force dut_a.txn_q = 16'hFFFE;
        #1;
        release dut_a.txn_q;
        exp_txn = 16'hFFFE;
        for (int unsigned i = 0; i < 3; i++) begin
            txn_a(1'b0, 32'(i), 32'd0, 0, rd, er);
            chk($sformatf("sat%0d", i), 32'(a_txn_count), 32'h0000FFFF);
        end

        // LATENCY=1 with req_valid held high: accept every 2 cycles, response 1 cycle later.
        @(negedge CLK);
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            b_req_addr  = 32'(k);
            b_req_wdata = 32'h100 + 32'(k);
            chk($sformatf("b2b_ready%0d", k), 32'(b_req_ready), 32'((k % 2) == 0));
            chk($sformatf("b2b_valid%0d", k), 32'(b_rsp_valid), 32'((k % 2) == 1));
            if ((k % 2) == 1) chk($sformatf("b2b_rdata%0d", k), b_rsp_rdata, 32'd0);
            @(negedge CLK);
        end
        b_req_valid = 1'b0;
        chk("b2b_txn", 32'(b_txn_count), 32'd4);
        for (int unsigned j = 0; j < 2; j++) begin
            b_req_we    = 1'b0;
            b_req_addr  = 32'd2 + 32'd4 * 32'(j);
            b_req_valid = 1'b1;
            @(posedge CLK);
            #1;
            b_req_valid = 1'b0;
            @(negedge CLK);
            chk($sformatf("b_load_valid%0d", j), 32'(b_rsp_valid), 32'd1);
            chk($sformatf("b_load_rdata%0d", j), b_rsp_rdata, 32'h102 + 32'd4 * 32'(j));
            chk($sformatf("b_load_err%0d", j), 32'(b_rsp_err), 32'd0);
            @(negedge CLK);
        end
        chk("b_final_txn", 32'(b_txn_count), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
